// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the M-extension sequencer: funct3 codes,
// the multiply/divide FSM state type, and the default XLEN.
package rv32_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: shift-add multiplier / restoring divider sharing one
// hi/lo register pair (hi = accumulator or remainder, lo = multiplier or quotient).
module muldiv_iter_dp
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_fix,
    input  logic            i_op_mul,
    input  logic            i_neg_lo,
    input  logic            i_neg_hi,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_sub;
    logic              w_borrow;
    logic [2*XLEN-1:0] w_prod_neg;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift   = {r_hi, r_lo[XLEN-1]};
    assign w_sub     = {1'b0, w_shift} - {2'b00, r_b};
    assign w_borrow  = w_sub[XLEN+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_b  <= i_b;
        end else if (i_step) begin
            if (i_op_mul) begin
                // {carry,sum,lo} >> 1: the adder carry becomes the new hi MSB
                r_hi <= w_mul_sum[XLEN:1];
                r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end else begin
                r_hi <= w_borrow ? w_shift[XLEN-1:0] : w_sub[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], ~w_borrow};
            end
        end
    end

    assign w_prod_neg = '0 - {r_hi, r_lo};

    always_comb begin
        o_hi = r_hi;
        o_lo = r_lo;
        if (i_fix) begin
            if (i_op_mul) begin
                if (i_neg_lo) {o_hi, o_lo} = w_prod_neg;
            end else begin
                if (i_neg_lo) o_lo = '0 - r_lo;
                if (i_neg_hi) o_hi = '0 - r_hi;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide controller: FSM, counter, fast paths, result mux, stall.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_sequencer
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;

    logic            w_is_mul, w_is_rem, w_sgn_a, w_sgn_b;
    logic            w_a_neg, w_b_neg, w_div0, w_ovf, w_fast;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_fast_res, w_fix_res, w_res_nxt;
    logic [XLEN-1:0] w_dp_hi, w_dp_lo;
    logic            w_load, w_step, w_fix, w_res_we;

    assign w_is_mul = ~r_f3[2];
    assign w_is_rem = r_f3[2] & r_f3[1];
    assign w_sgn_a  = (r_f3 == F3_MULH) | (r_f3 == F3_MULHSU) | (r_f3 == F3_DIV) | (r_f3 == F3_REM);
    assign w_sgn_b  = (r_f3 == F3_MULH) | (r_f3 == F3_DIV) | (r_f3 == F3_REM);
    assign w_a_neg  = w_sgn_a & r_a[XLEN-1];
    assign w_b_neg  = w_sgn_b & r_b[XLEN-1];
    assign w_abs_a  = w_a_neg ? '0 - r_a : r_a;
    assign w_abs_b  = w_b_neg ? '0 - r_b : r_b;

    assign w_div0     = r_f3[2] & (r_b == '0);
    assign w_ovf      = r_f3[2] & w_sgn_b & (r_a == {1'b1, {(XLEN-1){1'b0}}}) & (r_b == '1);
    assign w_fast     = w_div0 | w_ovf;
    assign w_fast_res = w_div0 ? (w_is_rem ? r_a : '1) : (w_is_rem ? '0 : r_a);

    muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_fix    (w_fix),
        .i_op_mul (w_is_mul),
        .i_neg_lo (w_a_neg ^ w_b_neg),
        .i_neg_hi (w_is_mul ? (w_a_neg ^ w_b_neg) : w_a_neg),
        .i_a      (w_abs_a),
        .i_b      (w_abs_b),
        .o_hi     (w_dp_hi),
        .o_lo     (w_dp_lo)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] w_fast_full;
    logic [2*XLEN-1:0]        r_prod;

    assign w_fast_full = $signed({w_a_neg, r_a}) * $signed({w_b_neg, r_b});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prod <= '0;
        else if (r_state == S_PREP) r_prod <= w_fast_full[2*XLEN-1:0];
    end

    always_comb begin
        if (r_f3 == F3_MUL)  w_fix_res = r_prod[XLEN-1:0];
        else if (w_is_mul)   w_fix_res = r_prod[2*XLEN-1:XLEN];
        else if (w_is_rem)   w_fix_res = w_dp_hi;
        else                 w_fix_res = w_dp_lo;
    end
`else
    always_comb begin
        if (r_f3 == F3_MUL)  w_fix_res = w_dp_lo;
        else if (w_is_mul)   w_fix_res = w_dp_hi;
        else if (w_is_rem)   w_fix_res = w_dp_hi;
        else                 w_fix_res = w_dp_lo;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_fix     = 1'b0;
        w_res_we  = 1'b0;
        w_res_nxt = w_fix_res;
        case (r_state)
            S_IDLE: if (start && !flush) w_next = S_PREP;
            S_PREP: begin
                w_load = 1'b1;
                if (flush) w_next = S_IDLE;
                else if (w_fast) begin
                    w_res_we  = 1'b1;
                    w_res_nxt = w_fast_res;
                    w_next    = S_DONE;
                end
                else if (FAST_MUL && w_is_mul) w_next = S_FIX;
                else w_next = S_CALC;
            end
            S_CALC: begin
                w_step = 1'b1;
                if (flush) w_next = S_IDLE;
                else if (r_cnt == CNT_W'(XLEN-1)) w_next = S_FIX;
            end
            S_FIX: begin
                w_fix = 1'b1;
                if (flush) w_next = S_IDLE;
                else begin
                    w_res_we = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f3     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (r_state == S_IDLE && start && !flush) begin
                r_f3 <= funct3;
                r_a  <= op_a;
                r_b  <= op_b;
            end
            if (r_state == S_PREP)      r_cnt <= '0;
            else if (r_state == S_CALC) r_cnt <= r_cnt + CNT_W'(1);
            if (w_res_we) r_result <= w_res_nxt;
        end
    end

    assign stall  = ((r_state == S_IDLE) & start & ~flush) |
                    (r_state == S_PREP) | (r_state == S_CALC) | (r_state == S_FIX);
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, flush/reset
// scenarios and randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 35;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_err    = 0;

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 < 3'd4) return MUL_LAT;
        if (b == 0) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Issue one op in cycle 0, then track stall/done until completion.
    // hold=1 keeps start high and scrambles the operand inputs while busy.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                         input bit hold);
        int cyc;
        int nstall;
        bit seen;
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        #1 check({tag, "_stall_c0"}, {31'b0, stall}, 32'd1);
        cyc = 0; nstall = 0; seen = 1'b0;
        while (!seen && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
            end else start = 1'b0;
            #1;
            if (done) seen = 1'b1;
            else if (cyc <= exp_lat - 2 && stall) nstall++;
        end
        check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_stall_run"}, nstall, exp_lat - 2);
        check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
        check({tag, "_result"}, result, exp_res);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
        check({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        bit          saw_done;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);

        do_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b1);
        do_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
        do_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
        do_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b0);
        do_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b0);
        do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 35, 1'b1);
        do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 35, 1'b0);
        do_op("div_5_0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
        do_op("remu_5_0", 3'd7, 32'd5, 32'd0, 32'd5, 2, 1'b0);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);

        // flush a DIV in cycle 10
        prev = result;
        @(negedge clk);
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        saw_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            #1 if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy_c11", {31'b0, busy}, 32'd0);
        check("flush_no_done", {31'b0, saw_done | done}, 32'd0);
        check("flush_result_kept", result, prev);
        do_op("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333, 35, 1'b0);

        // flush beats start in IDLE
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1; flush = 1'b1;
        #1 check("flush_vs_start_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 check("flush_vs_start_busy", {31'b0, busy}, 32'd0);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd77; op_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1 check("pre_rst_busy", {31'b0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_done", {31'b0, done}, 32'd0);
        check("async_rst_result", result, 32'd0);
        #1 rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 200)) - 32'd100; rb = 32'($urandom_range(1, 20)); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            do_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, ref_model(rf, ra, rb),
                  ref_lat(rf, ra, rb), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
